// File: rtl/multi_step_pulse_gen.sv
// Multi-channel button front end.
// Each channel has a 2-FF synchroniser, a debouncer, and a press FSM.
// The FSM produces step, release, long-press and auto-repeat indications.
// Every output is registered.
module multi_step_pulse_gen #(
  parameter int unsigned          N_CH     = 5,
  parameter int unsigned          DEB_CYC  = 100000,
  parameter int unsigned          HOLD_CYC = 50000000,
  parameter int unsigned          RPT_CYC  = 10000000,
  parameter logic [N_CH-1:0]      RPT_EN   = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] btn,
  output logic [N_CH-1:0] level,
  output logic [N_CH-1:0] step_pulse,
  output logic [N_CH-1:0] release_pulse,
  output logic [N_CH-1:0] long_press,
  output logic            any_pulse
);

  // state   | meaning
  // IDLE    | debounced level low, waiting for a press
  // PRESSED | held, counting toward long press (frozen once declared without repeat)
  // REPEAT  | long press with auto-repeat, stepping every RPT_CYC cycles
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    REPEAT  = 2'd2
  } state_t;

  localparam int unsigned DW     = $clog2(DEB_CYC + 1);
  localparam int unsigned HMAX   = (HOLD_CYC > RPT_CYC) ? HOLD_CYC : RPT_CYC;
  localparam int unsigned HW     = $clog2(HMAX + 1);
  localparam logic [DW-1:0] DEB_TC  = DW'(DEB_CYC - 1);
  localparam logic [HW-1:0] HOLD_TC = HW'(HOLD_CYC - 1);
  localparam logic [HW-1:0] RPT_TC  = HW'(RPT_CYC - 1);

  logic [N_CH-1:0] sync1_q;
  logic [N_CH-1:0] sync2_q;
  logic [N_CH-1:0] step_nxt;

  // Two-stage synchroniser for the asynchronous buttons.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= btn;
      sync2_q <= sync1_q;
    end
  end

  // Combined step indicator, registered alongside the per-channel step pulses.
  always_ff @(posedge clk) begin
    if (!rst) any_pulse <= 1'b0;
    else      any_pulse <= |step_nxt;
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [DW-1:0] cnt_q, cnt_d;
    logic          level_q, lvl_d;
    state_t        state_q, state_d;
    logic [HW-1:0] hcnt_q, hcnt_d;
    logic          long_q, long_d;
    logic          step_q, step_d;
    logic          rel_q, rel_d;

    // Debounce: the level follows the synchronised input only after DEB_CYC
    // consecutive disagreeing cycles.
    always_comb begin
      cnt_d = '0;
      lvl_d = level_q;
      if (sync2_q[i] != level_q) begin
        if (cnt_q == DEB_TC) begin
          lvl_d = sync2_q[i];
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + DW'(1);
        end
      end
    end

    // Press FSM. It acts on the next debounced level, so the step and release
    // pulses register on the same edge as the level change.
    always_comb begin
      state_d = state_q;
      hcnt_d  = hcnt_q;
      long_d  = long_q;
      step_d  = 1'b0;
      rel_d   = 1'b0;
      case (state_q)
        IDLE: begin
          if (lvl_d && !level_q) begin
            state_d = PRESSED;
            step_d  = 1'b1;
            hcnt_d  = '0;
          end
        end
        PRESSED: begin
          if (!lvl_d) begin
            state_d = IDLE;
            rel_d   = 1'b1;
            long_d  = 1'b0;
            hcnt_d  = '0;
          end else if (!long_q) begin
            if (hcnt_q == HOLD_TC) begin
              long_d = 1'b1;
              hcnt_d = '0;
              if (RPT_EN[i]) begin
                step_d  = 1'b1;
                state_d = REPEAT;
              end
            end else begin
              hcnt_d = hcnt_q + HW'(1);
            end
          end
        end
        REPEAT: begin
          if (!lvl_d) begin
            state_d = IDLE;
            rel_d   = 1'b1;
            long_d  = 1'b0;
            hcnt_d  = '0;
          end else if (hcnt_q == RPT_TC) begin
            step_d = 1'b1;
            hcnt_d = '0;
          end else begin
            hcnt_d = hcnt_q + HW'(1);
          end
        end
        default: begin
          state_d = IDLE;
          hcnt_d  = '0;
          long_d  = 1'b0;
        end
      endcase
    end

    // Per-channel state and output registers.
    always_ff @(posedge clk) begin
      if (!rst) begin
        cnt_q   <= '0;
        level_q <= 1'b0;
        state_q <= IDLE;
        hcnt_q  <= '0;
        long_q  <= 1'b0;
        step_q  <= 1'b0;
        rel_q   <= 1'b0;
      end else begin
        cnt_q   <= cnt_d;
        level_q <= lvl_d;
        state_q <= state_d;
        hcnt_q  <= hcnt_d;
        long_q  <= long_d;
        step_q  <= step_d;
        rel_q   <= rel_d;
      end
    end

    assign step_nxt[i]      = step_d;
    assign level[i]         = level_q;
    assign step_pulse[i]    = step_q;
    assign release_pulse[i] = rel_q;
    assign long_press[i]    = long_q;
  end

endmodule
